// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, multi-cycle mul/div stall,
// taken-branch flush and load-use interlock, plus saturating stall/flush
// performance counters.
module hazard_ctrl #(
  parameter int MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_reg,
  input  logic        ex_write,
  input  logic        ex_is_load,
  input  logic        ex_md_start,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        memwb_bubble,
  output logic        md_done,
  output logic        busy,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  // The entry cycle in RUN is already a stall, so the counter starts two short.
  localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       mem_freeze, load_use, md_stall;

  assign mem_freeze = mem_req & ~mem_ready;
  assign load_use   = ex_is_load & ex_write & (ex_reg != 5'd0) &
                      ((id_uses_rs & (ex_reg == id_rs)) |
                       (id_uses_rt & (ex_reg == id_rt)));
  assign md_stall   = ((state == RUN) & ex_md_start) |
                      ((state == MD_BUSY) & (md_cnt != 4'd0));
  assign busy       = (state == MD_BUSY);

  // Mul/div sequencing; a memory freeze holds the op where it is.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    md_done    = 1'b0;
    case (state)
      RUN: begin
        if (ex_md_start && !mem_freeze) begin
          state_nxt  = MD_BUSY;
          md_cnt_nxt = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (!mem_freeze) begin
          if (md_cnt != 4'd0) begin
            md_cnt_nxt = md_cnt - 4'd1;
          end else begin
            md_done   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Pipeline control, highest-priority hazard wins.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    if (mem_freeze) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (md_stall) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_bubble = 1'b1;
    end else if (branch_taken) begin
      // A taken branch discards the ID instruction, so any load-use is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // FSM state register; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (pc_stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule
